alu_issue: RTL and testbench
============================

// Module: alu_issue
// PURPOSE
//  Issue side of the ALU interface. Decodes RV32I OP, OP-IMM and BRANCH instructions into ALU_CTL.
//  Drives registered operands into the combinational alu, and captures ALU_DC, ALU_ZERO and ALU_OverFlow.
//  Two-stage valid/ready pipeline (D = issue register, R = result register) between decode and writeback.
// PARAMETERS
//  XLEN      32  datapath width; only 32 is supported
//  RST_CTL   4'b0000  alu_ctl value while stage D is empty or in reset
// PORTS
//  clk          in   1     clock; all state updates on rising edge
//  rst_n        in   1     synchronous reset, active-low
//  flush        in   1     synchronous pipeline kill
//  in_valid     in   1     upstream instruction valid
//  in_ready     out  1     stage D can accept
//  in_opcode    in   7     instr[6:0]
//  in_funct3    in   3     instr[14:12]
//  in_funct7_5  in   1     instr[30]
//  in_rs1       in   32    rs1 value
//  in_rs2       in   32    rs2 value
//  in_imm       in   32    sign-extended I-immediate
//  in_rd        in   5     destination register
//  alu_da       out  32    to ALU_DA
//  alu_db       out  32    to ALU_DB
//  alu_ctl      out  4     to ALU_CTL
//  alu_dc       in   32    from ALU_DC
//  alu_zero     in   1     from ALU_ZERO
//  alu_ovf      in   1     from ALU_OverFlow
//  out_valid    out  1     stage R holds a result
//  out_ready    in   1     downstream accepts
//  out_result   out  32    registered ALU_DC
//  out_rd       out  5     destination register
//  out_wen      out  1     write rd (OP/OP-IMM, rd!=0, legal)
//  out_br       out  1     result is a branch decision
//  out_br_taken out  1     branch taken
//  out_illegal  out  1     undecodable instruction
//  out_ovf      out  1     signed overflow flag (see CONFIGURATION)
// BEHAVIOUR
//  ALU_CTL map: 0000 add, 0001 add+ovf, 0010 sub, 0011 sub+ovf, 0100 and, 0101 or, 0110 xor, 0111 nor,
//   1000 sltu, 1001 slt, 1100 sll, 1101 srl, 1110 sra. 1010/1011/1111 are never issued.
//  Decode, f3 = funct3:
//   - OP: f3 000 add (sub if f7_5), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl (sra if f7_5), 110 or, 111 and.
//     f7_5=1 with any other f3 -> illegal.
//   - OP-IMM: same table with alu_db=in_imm. 000 is always add. f7_5 selects sra only on 101; f3 001 with f7_5=1 -> illegal.
//   - BRANCH: BEQ/BNE -> sub, taken = alu_zero / !alu_zero. BLT/BGE -> 1001, taken = dc[0] / !dc[0].
//     BLTU/BGEU -> 1000, same taken rule. f3 010/011 -> illegal.
//   - Any other opcode -> illegal.
//  Illegal instructions still flow through with out_illegal=1, out_wen=0, out_br=0, alu_ctl=RST_CTL.
//  Pipeline:
//   - in_ready = !D_valid | R_ready.  R_ready = !out_valid | out_ready.
//   - D registers alu_da/db/ctl and metadata. R captures alu_dc, the taken bit and the flags when D advances.
//   - Latency: accept at cycle N -> out_valid at N+2 under no backpressure. Throughput 1/cycle.
//   - Output registers hold stable while out_valid & !out_ready.
//   - When D is empty, alu_da/db hold their last value and alu_ctl = RST_CTL.
//  Flush: next cycle D_valid=0 and out_valid=0. An in_valid accepted in the flush cycle is discarded. Flush wins over all handshakes.
//  Reset (rst_n=0 at edge): all valids 0, alu_da/db/out_result=0, alu_ctl=RST_CTL, out_rd=0, all flags 0. Applies mid-operation too.
// CONFIGURATION
//  ALU_ISSUE_OVF_TRAP_EN defined:
//   - add/sub from OP/OP-IMM issue 0001/0011, and out_ovf = registered alu_ovf.
//   - Branches always use 0010 with out_ovf=0.
//  Undefined: add/sub issue 0000/0010 and out_ovf is tied to 0.
// STRUCTURE
//  alu_pkg: ALU_CTL localparams (ALU_ADD..ALU_SRA), opcode constants (OPC_OP/OPC_OPIMM/OPC_BRANCH) and the branch funct3 codes.
//  Sub-module alu_issue_dec: purely combinational opcode/f3/f7 -> {ctl, use_imm, is_br, br_kind, illegal}.
//  The alu itself is not instantiated; the top level connects it.
// TESTING
//  1. add x5, rs1=7, rs2=0xFFFFFFFF -> alu_ctl 0000 one cycle after accept; 2 cycles after accept out_result=6, out_rd=5, out_wen=1.
//  2. BLT rs1=0xFFFFFFFE, rs2=1 -> alu_ctl 1001, out_br=1, taken=1. Same operands with BLTU -> ctl 1000, taken=0.
//  3. srai, imm=0x404 -> ctl 1110. srli, imm=0x004 -> ctl 1101. slli with f7_5=1 -> out_illegal=1, out_wen=0.
//  4. Back-to-back stream of 4 ops with out_ready held 0 for 3 cycles:
//     in_ready drops after 2 accepts, no drops or duplicates, results emerge in order.
//  5. flush while both stages are full and in_valid=1 -> next cycle out_valid=0 and D empty; no stale result emitted.
//  6. OVF_TRAP_EN: add 0x7FFFFFFF+1 -> ctl 0001, out_ovf=1. Without the macro -> ctl 0000, out_ovf=0.
//     rst_n low mid-stream clears all outputs.

Source files
------------

// File: rtl/alu_pkg.sv
// Package: alu_pkg
// Shared constants for the ALU issue slice:
//   - ALU_CTL encodings driven to the external combinational ALU
//   - RV32I major opcodes handled by the issue stage
//   - BRANCH funct3 codes
//   - br_kind_e: which ALU result bit decides a branch
package alu_pkg;

  // ALU_CTL encodings. 1010, 1011 and 1111 are never issued.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_ADDV = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SUBV = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SRA  = 4'b1110;

  // RV32I major opcodes (instr[6:0]).
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // BRANCH funct3 codes. 010 and 011 are undefined.
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // How the captured ALU result turns into a taken bit.
  typedef enum logic [1:0] {
    BR_EQ = 2'd0,  // taken when alu_zero
    BR_NE = 2'd1,  // taken when !alu_zero
    BR_LT = 2'd2,  // taken when dc[0] (slt/sltu result)
    BR_GE = 2'd3   // taken when !dc[0]
  } br_kind_e;

endpackage

// File: rtl/alu_issue_dec.sv
// Module: alu_issue_dec
// Purely combinational decode of opcode/funct3/funct7[5] into ALU control
// and branch metadata.
// Ports:
//   opcode, funct3, funct7_5  in   instruction fields
//   ctl                       out  ALU_CTL to issue (RST_CTL when illegal)
//   use_imm                   out  operand B comes from the I-immediate
//   is_br                     out  legal BRANCH
//   br_kind                   out  br_kind_e, selects the taken rule
//   illegal                   out  undecodable instruction
// Configuration: ALU_ISSUE_OVF_TRAP_EN makes OP/OP-IMM add/sub issue the
// overflow-reporting encodings; branches always use plain sub.
module alu_issue_dec
  import alu_pkg::*;
#(
  parameter logic [3:0] RST_CTL = 4'b0000
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] ctl,
  output logic       use_imm,
  output logic       is_br,
  output logic [1:0] br_kind,
  output logic       illegal
);

`ifdef ALU_ISSUE_OVF_TRAP_EN
  localparam logic [3:0] ARITH_ADD = ALU_ADDV;
  localparam logic [3:0] ARITH_SUB = ALU_SUBV;
`else
  localparam logic [3:0] ARITH_ADD = ALU_ADD;
  localparam logic [3:0] ARITH_SUB = ALU_SUB;
`endif

  logic is_imm;
  assign is_imm = (opcode == OPC_OPIMM);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    ctl     = RST_CTL;
    use_imm = is_imm;  // illegal instructions keep the opcode's operand routing
    is_br   = 1'b0;
    br_kind = BR_EQ;
    illegal = 1'b0;

    case (opcode)
      OPC_OP, OPC_OPIMM: begin
        case (funct3)
          3'b000: ctl = (!is_imm && funct7_5) ? ARITH_SUB : ARITH_ADD;
          3'b001: ctl = ALU_SLL;
          3'b010: ctl = ALU_SLT;
          3'b011: ctl = ALU_SLTU;
          3'b100: ctl = ALU_XOR;
          3'b101: ctl = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110: ctl = ALU_OR;
          3'b111: ctl = ALU_AND;
          default: ctl = RST_CTL;
        endcase
        // OP only allows funct7[5] on add/sub and srl/sra. For OP-IMM the bit
        // is part of the immediate except on the shifts, where slli must be 0.
        if (funct7_5) begin
          if (is_imm)
            illegal = (funct3 == 3'b001);
          else
            illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
        end
      end
      OPC_BRANCH: begin
        is_br = 1'b1;
        case (funct3)
          F3_BEQ:  begin ctl = ALU_SUB;  br_kind = BR_EQ; end
          F3_BNE:  begin ctl = ALU_SUB;  br_kind = BR_NE; end
          F3_BLT:  begin ctl = ALU_SLT;  br_kind = BR_LT; end
          F3_BGE:  begin ctl = ALU_SLT;  br_kind = BR_GE; end
          F3_BLTU: begin ctl = ALU_SLTU; br_kind = BR_LT; end
          F3_BGEU: begin ctl = ALU_SLTU; br_kind = BR_GE; end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase

    // Illegal instructions still flow down the pipe but must not look like
    // a branch or request a real ALU operation.
    if (illegal) begin
      ctl   = RST_CTL;
      is_br = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Module: alu_issue
// Issue side of the ALU interface. Decodes RV32I OP/OP-IMM/BRANCH, registers
// operands and control in stage D (driving the external combinational ALU),
// and captures the ALU result and flags in stage R for writeback.
// Ports:
//   clk, rst_n (synchronous, active-low), flush (synchronous pipeline kill)
//   in_valid/in_ready, in_opcode, in_funct3, in_funct7_5, in_rs1, in_rs2,
//     in_imm, in_rd                       upstream instruction
//   alu_da, alu_db, alu_ctl               to the ALU
//   alu_dc, alu_zero, alu_ovf             from the ALU
//   out_valid/out_ready, out_result, out_rd, out_wen, out_br,
//     out_br_taken, out_illegal, out_ovf  downstream result
// Configuration: define ALU_ISSUE_OVF_TRAP_EN to issue add/sub with overflow
// reporting and return the registered ALU overflow on out_ovf; otherwise
// out_ovf is always 0.
module alu_issue
  import alu_pkg::*;
#(
  parameter int         XLEN    = 32,
  parameter logic [3:0] RST_CTL = 4'b0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_5,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rd,
  output logic [XLEN-1:0] alu_da,
  output logic [XLEN-1:0] alu_db,
  output logic [3:0]      alu_ctl,
  input  logic [XLEN-1:0] alu_dc,
  input  logic            alu_zero,
  input  logic            alu_ovf,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_br,
  output logic            out_br_taken,
  output logic            out_illegal,
  output logic            out_ovf
);

  // Decode
  logic [3:0] dec_ctl;
  logic       dec_use_imm;
  logic       dec_is_br;
  logic [1:0] dec_br_kind;
  logic       dec_illegal;

  alu_issue_dec #(.RST_CTL(RST_CTL)) u_dec (
    .opcode   (in_opcode),
    .funct3   (in_funct3),
    .funct7_5 (in_funct7_5),
    .ctl      (dec_ctl),
    .use_imm  (dec_use_imm),
    .is_br    (dec_is_br),
    .br_kind  (dec_br_kind),
    .illegal  (dec_illegal)
  );

  // Stage D state
  logic       d_valid;
  logic [3:0] d_ctl;
  logic [4:0] d_rd;
  logic       d_wen;
  logic       d_br;
  logic [1:0] d_br_kind;
  logic       d_illegal;

  // Handshakes. Flush suppresses the loads but not the ready outputs.
  logic r_ready;
  logic d_load;
  logic r_load;

  assign r_ready  = !out_valid || out_ready;
  assign in_ready = !d_valid || r_ready;
  assign d_load   = in_valid && in_ready && !flush;
  assign r_load   = d_valid && r_ready && !flush;

  assign alu_ctl = d_valid ? d_ctl : RST_CTL;

  // Branch decision from the live ALU result of the instruction in D.
  logic br_cond;
  always_comb begin
    br_cond = 1'b0;
    case (d_br_kind)
      BR_EQ:   br_cond = alu_zero;
      BR_NE:   br_cond = !alu_zero;
      BR_LT:   br_cond = alu_dc[0];
      BR_GE:   br_cond = !alu_dc[0];
      default: br_cond = 1'b0;
    endcase
  end

  logic ovf_next;
`ifdef ALU_ISSUE_OVF_TRAP_EN
  assign ovf_next = alu_ovf && !d_br;
`else
  logic unused_alu_ovf;
  assign unused_alu_ovf = alu_ovf;
  assign ovf_next = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_valid      <= 1'b0;
      d_ctl        <= RST_CTL;
      d_rd         <= '0;
      d_wen        <= 1'b0;
      d_br         <= 1'b0;
      d_br_kind    <= BR_EQ;
      d_illegal    <= 1'b0;
      alu_da       <= '0;
      alu_db       <= '0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_rd       <= '0;
      out_wen      <= 1'b0;
      out_br       <= 1'b0;
      out_br_taken <= 1'b0;
      out_illegal  <= 1'b0;
      out_ovf      <= 1'b0;
    end else begin
      // Stage D occupancy
      if (flush)
        d_valid <= 1'b0;
      else if (d_load)
        d_valid <= 1'b1;
      else if (r_load)
        d_valid <= 1'b0;

      // Operands only change on a real load, so they hold while D is empty.
      if (d_load) begin
        alu_da    <= in_rs1;
        alu_db    <= dec_use_imm ? in_imm : in_rs2;
        d_ctl     <= dec_ctl;
        d_rd      <= in_rd;
        d_wen     <= !dec_illegal && !dec_is_br && (in_rd != 5'd0);
        d_br      <= dec_is_br;
        d_br_kind <= dec_br_kind;
        d_illegal <= dec_illegal;
      end

      // Stage R occupancy
      if (flush)
        out_valid <= 1'b0;
      else if (r_load)
        out_valid <= 1'b1;
      else if (out_ready)
        out_valid <= 1'b0;

      if (r_load) begin
        out_result   <= alu_dc;
        out_rd       <= d_rd;
        out_wen      <= d_wen;
        out_br       <= d_br;
        out_br_taken <= d_br && br_cond;
        out_illegal  <= d_illegal;
        out_ovf      <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Testbench: tb_alu_issue
// Table of instruction vectors with hand-derived results, a behavioural ALU
// connected to alu_da/db/ctl, and a scoreboard queue filled on accept and
// drained on each output handshake. Expectations follow ALU_ISSUE_OVF_TRAP_EN.
module tb_alu_issue;
  import alu_pkg::*;

`ifdef ALU_ISSUE_OVF_TRAP_EN
  localparam logic [3:0] ADDC   = 4'b0001;
  localparam logic [3:0] SUBC   = 4'b0011;
  localparam logic       OVF_ON = 1'b1;
`else
  localparam logic [3:0] ADDC   = 4'b0000;
  localparam logic [3:0] SUBC   = 4'b0010;
  localparam logic       OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, in_funct7_5;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1, in_rs2, in_imm;
  logic [4:0]  in_rd;
  logic [31:0] alu_da, alu_db, alu_dc;
  logic [3:0]  alu_ctl;
  logic        alu_zero, alu_ovf;
  logic        out_valid, out_ready, out_wen, out_br, out_br_taken, out_illegal, out_ovf;
  logic [31:0] out_result;
  logic [4:0]  out_rd;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
    .alu_da(alu_da), .alu_db(alu_db), .alu_ctl(alu_ctl),
    .alu_dc(alu_dc), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wen(out_wen),
    .out_br(out_br), .out_br_taken(out_br_taken),
    .out_illegal(out_illegal), .out_ovf(out_ovf)
  );

  // Behavioural stand-in for the external combinational ALU.
  function automatic logic [32:0] alu_model(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    case (c)
      4'b0000: r = a + b;
      4'b0001: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'b0010: r = a - b;
      4'b0011: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = a ^ b;
      4'b0111: r = ~(a | b);
      4'b1000: r = {31'd0, a < b};
      4'b1001: r = {31'd0, $signed(a) < $signed(b)};
      4'b1100: r = a << b[4:0];
      4'b1101: r = a >> b[4:0];
      4'b1110: r = $signed(a) >>> b[4:0];
      default: r = '0;
    endcase
    return {v, r};
  endfunction

  logic [32:0] alu_res;
  always_comb begin
    alu_res  = alu_model(alu_ctl, alu_da, alu_db);
    alu_dc   = alu_res[31:0];
    alu_ovf  = alu_res[32];
    alu_zero = (alu_res[31:0] == 32'd0);
  end

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] rs1, rs2, imm;
    logic [4:0]  rd;
    logic [3:0]  ctl;
    logic [31:0] res;
    logic        wen, br, taken, ill, ovf;
  } vec_t;

  function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] imm, input logic [4:0] rd,
                              input logic [3:0] ctl, input logic [31:0] res,
                              input logic wen, input logic br, input logic taken,
                              input logic ill, input logic ovf);
    vec_t v;
    v.opc = opc; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.rd = rd;
    v.ctl = ctl; v.res = res; v.wen = wen; v.br = br; v.taken = taken; v.ill = ill; v.ovf = ovf;
    return v;
  endfunction

  localparam int NV = 20;
  vec_t tbl [NV];
  vec_t cur;
  vec_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   n_out = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: pop/compare on output handshake, push on accepted input.
  always @(negedge clk) begin
    vec_t e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          check("unexpected_output", {31'd0, out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_result", out_result, e.res);
          check("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
          check("out_flags{wen,br,taken,ill,ovf}",
                {27'd0, out_wen, out_br, out_br_taken, out_illegal, out_ovf},
                {27'd0, e.wen, e.br, e.taken, e.ill, e.ovf});
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(cur);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_opcode = v.opc; in_funct3 = v.f3; in_funct7_5 = v.f7;
    in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm; in_rd = v.rd;
    cur = v;
    in_valid = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int n0;
    logic acc;

    //         opc         f3      f7 rs1           rs2           imm           rd     ctl      res           wen br tk ill ovf
    tbl[0]  = mk(OPC_OP,     3'b000, 0, 32'd7,        32'hFFFFFFFF, 32'd0,        5'd5,  ADDC,    32'd6,        1, 0, 0, 0, 0);
    tbl[1]  = mk(OPC_BRANCH, 3'b100, 0, 32'hFFFFFFFE, 32'd1,        32'd0,        5'd1,  4'b1001, 32'd1,        0, 1, 1, 0, 0);
    tbl[2]  = mk(OPC_BRANCH, 3'b110, 0, 32'hFFFFFFFE, 32'd1,        32'd0,        5'd1,  4'b1000, 32'd0,        0, 1, 0, 0, 0);
    tbl[3]  = mk(OPC_OPIMM,  3'b101, 1, 32'h80000000, 32'd0,        32'h404,      5'd3,  4'b1110, 32'hF8000000, 1, 0, 0, 0, 0);
    tbl[4]  = mk(OPC_OPIMM,  3'b101, 0, 32'h80000000, 32'd0,        32'h004,      5'd4,  4'b1101, 32'h08000000, 1, 0, 0, 0, 0);
    tbl[5]  = mk(OPC_OPIMM,  3'b001, 1, 32'd1,        32'd0,        32'h401,      5'd2,  4'b0000, 32'h402,      0, 0, 0, 1, 0);
    tbl[6]  = mk(OPC_OP,     3'b000, 0, 32'h7FFFFFFF, 32'd1,        32'd0,        5'd6,  ADDC,    32'h80000000, 1, 0, 0, 0, OVF_ON);
    tbl[7]  = mk(OPC_OP,     3'b000, 1, 32'd5,        32'd7,        32'd0,        5'd7,  SUBC,    32'hFFFFFFFE, 1, 0, 0, 0, 0);
    tbl[8]  = mk(OPC_BRANCH, 3'b000, 0, 32'd9,        32'd9,        32'd0,        5'd0,  4'b0010, 32'd0,        0, 1, 1, 0, 0);
    tbl[9]  = mk(OPC_BRANCH, 3'b001, 0, 32'd9,        32'd9,        32'd0,        5'd0,  4'b0010, 32'd0,        0, 1, 0, 0, 0);
    tbl[10] = mk(OPC_BRANCH, 3'b101, 0, 32'hFFFFFFFE, 32'd1,        32'd0,        5'd0,  4'b1001, 32'd1,        0, 1, 0, 0, 0);
    tbl[11] = mk(OPC_BRANCH, 3'b111, 0, 32'hFFFFFFFE, 32'd1,        32'd0,        5'd0,  4'b1000, 32'd0,        0, 1, 1, 0, 0);
    tbl[12] = mk(OPC_OP,     3'b100, 0, 32'h0000F0F0, 32'h0000FF00, 32'd0,        5'd8,  4'b0110, 32'h00000FF0, 1, 0, 0, 0, 0);
    tbl[13] = mk(OPC_OP,     3'b111, 0, 32'h0000F0F0, 32'h0000FF00, 32'd0,        5'd9,  4'b0100, 32'h0000F000, 1, 0, 0, 0, 0);
    tbl[14] = mk(OPC_OP,     3'b010, 0, 32'hFFFFFFFE, 32'd1,        32'd0,        5'd10, 4'b1001, 32'd1,        1, 0, 0, 0, 0);
    tbl[15] = mk(OPC_OP,     3'b001, 0, 32'd1,        32'h21,       32'd0,        5'd11, 4'b1100, 32'd2,        1, 0, 0, 0, 0);
    tbl[16] = mk(OPC_OP,     3'b100, 1, 32'd3,        32'd4,        32'd0,        5'd12, 4'b0000, 32'd7,        0, 0, 0, 1, 0);
    tbl[17] = mk(7'b0110111, 3'b000, 0, 32'd2,        32'd3,        32'd0,        5'd13, 4'b0000, 32'd5,        0, 0, 0, 1, 0);
    tbl[18] = mk(OPC_BRANCH, 3'b010, 0, 32'd4,        32'd5,        32'd0,        5'd14, 4'b0000, 32'd9,        0, 0, 0, 1, 0);
    tbl[19] = mk(OPC_OPIMM,  3'b000, 1, 32'd10,       32'd0,        32'h400,      5'd0,  ADDC,    32'h40A,      0, 0, 0, 0, 0);

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_funct3 = '0; in_funct7_5 = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_rd = '0;
    cur = tbl[0];

    // Reset state
    repeat (2) tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_alu_ctl", {28'd0, alu_ctl}, 32'd0);
    check("rst_alu_da", alu_da, 32'd0);
    check("rst_alu_db", alu_db, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_rd", {27'd0, out_rd}, 32'd0);
    check("rst_flags", {27'd0, out_wen, out_br, out_br_taken, out_illegal, out_ovf}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Table: one instruction at a time, control after 1 cycle, result after 2.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      tick();
      in_valid = 1'b0;
      check($sformatf("ctl[%0d]", i), {28'd0, alu_ctl}, {28'd0, tbl[i].ctl});
      tick();
      check($sformatf("latency_valid[%0d]", i), {31'd0, out_valid}, 32'd1);
    end
    tick();
    check("idle_ctl", {28'd0, alu_ctl}, 32'd0);
    check("idle_da_hold", alu_da, tbl[NV-1].rs1);
    check("idle_sb_empty", sb.size(), 32'd0);

    // Back-to-back stream with 3 cycles of backpressure.
    n0 = n_out;
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      out_ready = (c >= 3);
      drive(tbl[k]);
      @(negedge clk);
      acc = in_ready;
      if (c == 2) begin
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall_accepts", k, 32'd2);
      end
      tick();
      if (acc) k++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_accepts", k, 32'd4);
    for (int c = 0; c < 10 && (sb.size() != 0 || out_valid); c++) tick();
    check("stream_drained", sb.size(), 32'd0);
    check("stream_out_count", n_out - n0, 32'd4);

    // Flush with both stages full and a pending input.
    out_ready = 1'b0;
    drive(tbl[4]); tick();
    drive(tbl[5]); tick();
    check("pre_flush_valid", {31'd0, out_valid}, 32'd1);
    check("pre_flush_in_ready", {31'd0, in_ready}, 32'd0);
    drive(tbl[6]);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_d_empty_ctl", {28'd0, alu_ctl}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    n0 = n_out;
    repeat (4) tick();
    check("flush_no_stale", n_out - n0, 32'd0);

    // Flush discards an instruction accepted in the flush cycle.
    drive(tbl[7]); tick();
    drive(tbl[8]);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_accept_ctl", {28'd0, alu_ctl}, 32'd0);
    check("flush_accept_valid", {31'd0, out_valid}, 32'd0);
    n0 = n_out;
    repeat (3) tick();
    check("flush_accept_none", n_out - n0, 32'd0);

    // Reset in the middle of a stalled stream.
    out_ready = 1'b0;
    drive(tbl[0]); tick();
    drive(tbl[1]); tick();
    in_valid = 1'b0;
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_out_result", out_result, 32'd0);
    check("mrst_out_rd", {27'd0, out_rd}, 32'd0);
    check("mrst_flags", {27'd0, out_wen, out_br, out_br_taken, out_illegal, out_ovf}, 32'd0);
    check("mrst_alu_da", alu_da, 32'd0);
    check("mrst_alu_ctl", {28'd0, alu_ctl}, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    drive(tbl[6]); tick();
    in_valid = 1'b0;
    check("post_rst_ctl", {28'd0, alu_ctl}, {28'd0, tbl[6].ctl});
    repeat (3) tick();
    check("post_rst_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
